// File: rtl/oled_frame_buffer.sv
// Double-buffered 96x64 RGB565 frame store: one bank is drawn while the other serves
// pixel_index lookups; banks swap only on a frame_begin rising edge after a commit.
//
// state      | meaning
// ST_CLEAR   | fill draw bank with CLEAR_COLOUR, one word per cycle
// ST_DRAW    | accept pixel writes into draw bank until wr_commit
// ST_WAIT_SWAP | draw bank complete, waiting for the next frame_begin rise
module oled_frame_buffer #(
  parameter int unsigned WIDTH        = 96,
  parameter int unsigned HEIGHT       = 64,
  parameter logic [15:0] CLEAR_COLOUR = 16'h0000
) (
  input  logic        clock_100mhz,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_x,
  input  logic [5:0]  wr_y,
  input  logic [15:0] wr_colour,
  input  logic        wr_commit,
  output logic        swap_pending,
  input  logic [12:0] pixel_index,
  input  logic        frame_begin,
  output logic [15:0] oled_data
);

  localparam int unsigned DEPTH     = WIDTH * HEIGHT;
  localparam logic [12:0] LAST_ADDR = 13'(DEPTH - 1);

  typedef enum logic [1:0] {ST_CLEAR, ST_DRAW, ST_WAIT_SWAP} state_e;

  state_e      state_q, state_d;
  logic [12:0] clr_addr_q, clr_addr_d;
  logic        disp_sel_q, disp_sel_d;
  logic        shown_q, shown_d;
  logic        swap_pending_q, swap_pending_d;
  logic [15:0] oled_data_q, oled_data_d;
  logic        fb_meta_q, fb_meta_d;
  logic        fb_sync_q, fb_sync_d;

  logic        fb_rise;
  logic [12:0] wr_addr;
  logic        wr_in_range;
  logic        rd_in_range;
  logic        mem_we;
  logic [12:0] mem_waddr;
  logic [15:0] mem_wdata;

  logic [15:0] bank0_mem [DEPTH];
  logic [15:0] bank1_mem [DEPTH];

  assign wr_addr     = 13'(wr_y) * 13'(WIDTH) + 13'(wr_x);
  assign wr_in_range = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
  assign rd_in_range = 32'(pixel_index) < DEPTH;
  assign fb_rise     = fb_meta_q & ~fb_sync_q;

  assign wr_ready     = (state_q == ST_DRAW);
  assign swap_pending = swap_pending_q;
  assign oled_data    = oled_data_q;

  always_comb begin
    state_d        = state_q;
    clr_addr_d     = clr_addr_q;
    disp_sel_d     = disp_sel_q;
    shown_d        = shown_q;
    swap_pending_d = swap_pending_q;
    fb_meta_d      = frame_begin;
    fb_sync_d      = fb_meta_q;
    mem_we         = 1'b0;
    mem_waddr      = clr_addr_q;
    mem_wdata      = CLEAR_COLOUR;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          clr_addr_d = '0;
          state_d    = ST_DRAW;
        end else begin
          clr_addr_d = clr_addr_q + 13'd1;
        end
      end
      ST_DRAW: begin
        // out-of-range requests still handshake, they just never touch the RAM
        mem_we    = wr_valid & wr_in_range;
        mem_waddr = wr_addr;
        mem_wdata = wr_colour;
        if (wr_commit) begin
          state_d        = ST_WAIT_SWAP;
          swap_pending_d = 1'b1;
        end
      end
      ST_WAIT_SWAP: begin
        if (fb_rise) begin
          disp_sel_d     = ~disp_sel_q;
          swap_pending_d = 1'b0;
          shown_d        = 1'b1;
          state_d        = ST_CLEAR;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // shown masks the never-initialised display bank until the first swap
  always_comb begin
    oled_data_d = CLEAR_COLOUR;
    if (shown_q && rd_in_range) begin
      oled_data_d = disp_sel_q ? bank1_mem[pixel_index] : bank0_mem[pixel_index];
    end
  end

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      state_q        <= ST_CLEAR;
      clr_addr_q     <= '0;
      disp_sel_q     <= 1'b0;
      shown_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      oled_data_q    <= CLEAR_COLOUR;
      fb_meta_q      <= 1'b0;
      fb_sync_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_addr_q     <= clr_addr_d;
      disp_sel_q     <= disp_sel_d;
      shown_q        <= shown_d;
      swap_pending_q <= swap_pending_d;
      oled_data_q    <= oled_data_d;
      fb_meta_q      <= fb_meta_d;
      fb_sync_q      <= fb_sync_d;
    end
  end

  // the draw bank is always the one not selected for display
  always_ff @(posedge clock_100mhz) begin
    if (mem_we && disp_sel_q) bank0_mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock_100mhz) begin
    if (mem_we && !disp_sel_q) bank1_mem[mem_waddr] <= mem_wdata;
  end

endmodule
